// File: rtl/alu_system.sv
// Register file, address register file, instruction register, ALU with
// registered flags and a 256x8 memory, wired through the A/B/C multiplexers.
module alu_system (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RSel,
  input  logic [3:0]  RF_TSel,
  input  logic [3:0]  ALU_FunSel,
  input  logic [1:0]  ARF_OutCSel,
  input  logic [1:0]  ARF_OutDSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [3:0]  ARF_RegSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  AOut,
  output logic [7:0]  BOut,
  output logic [7:0]  ALUOut,
  output logic [3:0]  ALUOutFlag,
  output logic [7:0]  ARF_AOut,
  output logic [7:0]  Address,
  output logic [7:0]  MemoryOut,
  output logic [7:0]  MuxAOut,
  output logic [7:0]  MuxBOut,
  output logic [7:0]  MuxCOut,
  output logic [15:0] IROut
);

  logic [7:0]  r_rf [8];   // 0-3: T1-T4, 4-7: R1-R4 (matches the port-select encoding)
  logic [7:0]  r_arf [4];  // AR, SP, PCpast, PC (matches the C/D select encoding)
  logic [15:0] r_ir;
  logic        r_z, r_c, r_n, r_o;
  logic [7:0]  r_mem [256] = '{default: 8'h00};

  logic [7:0]  w_rf_en;
  logic [7:0]  w_rf_next [8];
  logic [3:0]  w_arf_en;
  logic [7:0]  w_arf_next [4];
  logic [15:0] w_ir_next;
  logic [8:0]  w_sum;
  logic        w_c, w_o;

  function automatic logic [7:0] f_regop(input logic [1:0] fun, input logic [7:0] cur,
                                         input logic [7:0] din);
    case (fun)
      2'b00:   f_regop = 8'h00;
      2'b01:   f_regop = din;
      2'b10:   f_regop = cur - 8'd1;
      default: f_regop = cur + 8'd1;
    endcase
  endfunction

  assign w_arf_en = {ARF_RegSel[3], ARF_RegSel[0], ARF_RegSel[1], ARF_RegSel[2]};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      if (gi < 4) begin : g_t
        assign w_rf_en[gi] = RF_TSel[3-gi];
      end else begin : g_r
        assign w_rf_en[gi] = RF_RSel[7-gi];
      end
      assign w_rf_next[gi] = w_rf_en[gi] ? f_regop(RF_FunSel, r_rf[gi], MuxAOut) : r_rf[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_arf
      assign w_arf_next[gi] = w_arf_en[gi] ? f_regop(ARF_FunSel, r_arf[gi], MuxBOut)
                                           : r_arf[gi];
    end
  endgenerate

  always_comb begin
    w_ir_next = r_ir;
    if (IR_Enable) begin
      case (IR_Funsel)
        2'b00:   w_ir_next = 16'h0000;
        2'b01:   if (IR_LH) w_ir_next[15:8] = MemoryOut;
                 else       w_ir_next[7:0]  = MemoryOut;
        2'b10:   w_ir_next = r_ir - 16'd1;
        default: w_ir_next = r_ir + 16'd1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < 8; i++) r_rf[i] <= Reset ? w_rf_next[i] : 8'h00;
    for (int i = 0; i < 4; i++) r_arf[i] <= Reset ? w_arf_next[i] : 8'h00;
    r_ir <= Reset ? w_ir_next : 16'h0000;
  end

  assign AOut     = r_rf[RF_OutASel];
  assign BOut     = r_rf[RF_OutBSel];
  assign ARF_AOut = r_arf[ARF_OutCSel];
  assign Address  = r_arf[ARF_OutDSel];
  assign IROut    = r_ir;
  assign MuxCOut  = MuxCSel ? ARF_AOut : AOut;

  always_comb begin
    case (MuxASel)
      2'b00:   MuxAOut = ALUOut;
      2'b01:   MuxAOut = MemoryOut;
      2'b10:   MuxAOut = r_ir[7:0];
      default: MuxAOut = ARF_AOut;
    endcase
    case (MuxBSel)
      2'b00:   MuxBOut = ALUOut;
      2'b01:   MuxBOut = MemoryOut;
      2'b10:   MuxBOut = r_ir[7:0];
      default: MuxBOut = ARF_AOut;
    endcase
  end

  // C and O default to their registered values so non-affecting ops hold them.
  always_comb begin
    ALUOut = 8'h00;
    w_sum  = 9'h000;
    w_c    = r_c;
    w_o    = r_o;
    case (ALU_FunSel)
      4'h0: ALUOut = MuxCOut;
      4'h1: ALUOut = BOut;
      4'h2: ALUOut = ~MuxCOut;
      4'h3: ALUOut = ~BOut;
      4'h4, 4'h5: begin
        w_sum  = {1'b0, MuxCOut} + {1'b0, BOut} + {8'h00, (ALU_FunSel[0] & r_c)};
        ALUOut = w_sum[7:0];
        w_c    = w_sum[8];
        w_o    = (MuxCOut[7] == BOut[7]) && (w_sum[7] != MuxCOut[7]);
      end
      4'h6: begin
        w_sum  = {1'b0, MuxCOut} + {1'b0, ~BOut} + 9'd1;
        ALUOut = w_sum[7:0];
        w_c    = w_sum[8];
        w_o    = (MuxCOut[7] != BOut[7]) && (w_sum[7] != MuxCOut[7]);
      end
      4'h7: ALUOut = MuxCOut & BOut;
      4'h8: ALUOut = MuxCOut | BOut;
      4'h9: ALUOut = MuxCOut ^ BOut;
      4'hA: begin ALUOut = {MuxCOut[6:0], 1'b0};       w_c = MuxCOut[7]; end
      4'hB: begin ALUOut = {1'b0, MuxCOut[7:1]};       w_c = MuxCOut[0]; end
      4'hC: begin
        ALUOut = {MuxCOut[6:0], 1'b0};
        w_c    = MuxCOut[7];
        w_o    = MuxCOut[7] ^ MuxCOut[6];
      end
      4'hD: begin ALUOut = {MuxCOut[7], MuxCOut[7:1]}; w_c = MuxCOut[0]; end
      4'hE: begin ALUOut = {MuxCOut[6:0], r_c};        w_c = MuxCOut[7]; end
      default: begin ALUOut = {r_c, MuxCOut[7:1]};     w_c = MuxCOut[0]; end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      {r_z, r_c, r_n, r_o} <= 4'b0000;
    end else begin
      r_z <= (ALUOut == 8'h00);
      r_n <= ALUOut[7];
      r_c <= w_c;
      r_o <= w_o;
    end
  end

  assign ALUOutFlag = {r_z, r_c, r_n, r_o};

  always_ff @(posedge Clock) begin
    if (!Mem_CS && Mem_WR) r_mem[Address] <= ALUOut;
  end

  assign MemoryOut = (!Mem_CS && !Mem_WR) ? r_mem[Address] : 8'h00;

endmodule

// File: tb/tb_alu_system.sv
// Directed bench for alu_system: a behavioural model checked every cycle plus
// hand-computed literal expectations at the key steps.
module tb_alu_system;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  RF_OutASel = '0, RF_OutBSel = '0;
  logic [1:0]  RF_FunSel = '0;
  logic [3:0]  RF_RSel = '0, RF_TSel = '0, ALU_FunSel = '0, ARF_RegSel = '0;
  logic [1:0]  ARF_OutCSel = '0, ARF_OutDSel = '0, ARF_FunSel = '0;
  logic        IR_LH = 1'b0, IR_Enable = 1'b0;
  logic [1:0]  IR_Funsel = '0;
  logic        Mem_WR = 1'b0, Mem_CS = 1'b1;
  logic [1:0]  MuxASel = '0, MuxBSel = '0;
  logic        MuxCSel = 1'b0;
  logic [7:0]  AOut, BOut, ALUOut, ARF_AOut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut;
  logic [3:0]  ALUOutFlag;
  logic [15:0] IROut;

  alu_system dut (
    .Clock(Clock), .Reset(Reset),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .AOut(AOut), .BOut(BOut), .ALUOut(ALUOut), .ALUOutFlag(ALUOutFlag),
    .ARF_AOut(ARF_AOut), .Address(Address), .MemoryOut(MemoryOut), .MuxAOut(MuxAOut),
    .MuxBOut(MuxBOut), .MuxCOut(MuxCOut), .IROut(IROut)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int AR = 0, SP = 1, PCP = 2, PC = 3;
  logic [7:0]  m_rf [8];     // T1..T4 then R1..R4, as numbered by the select codes
  logic [7:0]  m_arf [4];
  logic [15:0] m_ir;
  logic        m_z, m_c, m_n, m_o;
  logic [7:0]  m_mem [256];
  bit          m_ok = 1'b0;
  logic [7:0]  e_aout, e_bout, e_arfa, e_addr, e_mem, e_muxa, e_muxb, e_muxc, e_alu;
  logic        e_c, e_o;

  initial foreach (m_mem[i]) m_mem[i] = 8'h00;

  function automatic logic [7:0] op8(input logic [1:0] fun, input logic [7:0] cur,
                                     input logic [7:0] din);
    int v;
    v = int'(cur);
    case (fun)
      2'b00:   v = 0;
      2'b01:   v = int'(din);
      2'b10:   v = (v + 255) % 256;
      default: v = (v + 1) % 256;
    endcase
    return 8'(v);
  endfunction

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic model_eval();
    int a, b, r, s, cf;
    e_aout = m_rf[RF_OutASel];
    e_bout = m_rf[RF_OutBSel];
    e_arfa = m_arf[ARF_OutCSel];
    e_addr = m_arf[ARF_OutDSel];
    e_mem  = (!Mem_CS && !Mem_WR) ? m_mem[e_addr] : 8'h00;
    e_muxc = MuxCSel ? e_arfa : e_aout;
    a = int'(e_muxc);
    b = int'(e_bout);
    cf = m_c ? 1 : 0;
    e_c = m_c;
    e_o = m_o;
    r = 0;
    case (ALU_FunSel)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = 255 - a;
      4'h3: r = 255 - b;
      4'h4, 4'h5: begin
        r = a + b + ((ALU_FunSel == 4'h5) ? cf : 0);
        s = sgn(a) + sgn(b) + ((ALU_FunSel == 4'h5) ? cf : 0);
        e_c = (r > 255);
        e_o = (s > 127) || (s < -128);
      end
      4'h6: begin
        r = a + (255 - b) + 1;
        s = sgn(a) - sgn(b);
        e_c = (r > 255);
        e_o = (s > 127) || (s < -128);
      end
      4'h7: r = int'(e_muxc & e_bout);
      4'h8: r = int'(e_muxc | e_bout);
      4'h9: r = int'(e_muxc ^ e_bout);
      4'hA: begin r = a * 2;               e_c = (a >= 128); end
      4'hB: begin r = a / 2;               e_c = (a % 2 == 1); end
      4'hC: begin
        r = a * 2;
        e_c = (a >= 128);
        e_o = (a >= 128) != ((a * 2) % 256 >= 128);
      end
      4'hD: begin r = a / 2 + ((a >= 128) ? 128 : 0); e_c = (a % 2 == 1); end
      4'hE: begin r = a * 2 + cf;          e_c = (a >= 128); end
      default: begin r = a / 2 + cf * 128; e_c = (a % 2 == 1); end
    endcase
    e_alu = 8'(r % 256);
    case (MuxASel)
      2'd0: e_muxa = e_alu;
      2'd1: e_muxa = e_mem;
      2'd2: e_muxa = m_ir[7:0];
      default: e_muxa = e_arfa;
    endcase
    case (MuxBSel)
      2'd0: e_muxb = e_alu;
      2'd1: e_muxb = e_mem;
      2'd2: e_muxb = m_ir[7:0];
      default: e_muxb = e_arfa;
    endcase
  endtask

  always @(posedge Clock) begin
    if (!Reset) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      foreach (m_arf[i]) m_arf[i] = 8'h00;
      m_ir = 16'h0000;
      {m_z, m_c, m_n, m_o} = 4'b0000;
      m_ok = 1'b1;
    end else if (m_ok) begin
      model_eval();
      if (!Mem_CS && Mem_WR) m_mem[e_addr] = e_alu;
      for (int i = 0; i < 4; i++) begin
        if (RF_TSel[3-i]) m_rf[i]   = op8(RF_FunSel, m_rf[i], e_muxa);
        if (RF_RSel[3-i]) m_rf[4+i] = op8(RF_FunSel, m_rf[4+i], e_muxa);
      end
      if (ARF_RegSel[3]) m_arf[PC]  = op8(ARF_FunSel, m_arf[PC], e_muxb);
      if (ARF_RegSel[2]) m_arf[AR]  = op8(ARF_FunSel, m_arf[AR], e_muxb);
      if (ARF_RegSel[1]) m_arf[SP]  = op8(ARF_FunSel, m_arf[SP], e_muxb);
      if (ARF_RegSel[0]) m_arf[PCP] = op8(ARF_FunSel, m_arf[PCP], e_muxb);
      if (IR_Enable) begin
        case (IR_Funsel)
          2'b00: m_ir = 16'h0000;
          2'b01: if (IR_LH) m_ir = {e_mem, m_ir[7:0]}; else m_ir = {m_ir[15:8], e_mem};
          2'b10: m_ir = 16'((int'(m_ir) + 65535) % 65536);
          default: m_ir = 16'((int'(m_ir) + 1) % 65536);
        endcase
      end
      m_z = (e_alu == 8'h00);
      m_n = e_alu[7];
      m_c = e_c;
      m_o = e_o;
    end
  end

  always @(negedge Clock) begin
    if (m_ok) begin
      model_eval();
      chk8("AOut", AOut, e_aout);
      chk8("BOut", BOut, e_bout);
      chk8("ALUOut", ALUOut, e_alu);
      chk8("ALUOutFlag", {4'h0, ALUOutFlag}, {4'h0, m_z, m_c, m_n, m_o});
      chk8("ARF_AOut", ARF_AOut, e_arfa);
      chk8("Address", Address, e_addr);
      chk8("MemoryOut", MemoryOut, e_mem);
      chk8("MuxAOut", MuxAOut, e_muxa);
      chk8("MuxBOut", MuxBOut, e_muxb);
      chk8("MuxCOut", MuxCOut, e_muxc);
      chk16("IROut", IROut, m_ir);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    RF_RSel = 4'b0000; RF_TSel = 4'b0000; ARF_RegSel = 4'b0000;
    IR_Enable = 1'b0; Mem_CS = 1'b1; Mem_WR = 1'b0;
  endtask

  logic [2:0] a_tab [3] = '{3'b100, 3'b001, 3'b010};
  logic [2:0] b_tab [3] = '{3'b000, 3'b001, 3'b100};

  initial begin
    tick();
    Reset = 1'b1;
    #1;
    $display("txn reset");
    chk8("reset AOut", AOut, 8'h00);
    chk8("reset BOut", BOut, 8'h00);
    chk16("reset IROut", IROut, 16'h0000);
    chk8("reset flags", {4'h0, ALUOutFlag}, 8'h00);
    chk8("reset Address", Address, 8'h00);

    RF_TSel = 4'b1000; RF_FunSel = 2'b11;
    tick(); tick();
    idle(); RF_OutASel = 3'b000; MuxCSel = 1'b0; ALU_FunSel = 4'h0;
    #1;
    $display("txn T1 increment twice");
    chk8("T1 pass ALUOut", ALUOut, 8'h02);
    tick();
    chk8("T1 pass flags", {4'h0, ALUOutFlag}, 8'h00);

    RF_RSel = 4'b1000; RF_FunSel = 2'b10;
    tick();
    idle(); RF_OutASel = 3'b100;
    #1;
    $display("txn R1 decrement from 0");
    chk8("R1 dec ALUOut", ALUOut, 8'hFF);
    tick();
    chk8("R1 dec flags", {4'h0, ALUOutFlag}, 8'h02);

    ALU_FunSel = 4'hB; MuxASel = 2'b00; RF_TSel = 4'b0100; RF_FunSel = 2'b01;
    #1;
    chk8("LSR FF", ALUOut, 8'h7F);
    tick();
    idle(); RF_TSel = 4'b1000; RF_FunSel = 2'b10;
    tick();
    idle(); RF_OutASel = 3'b001; RF_OutBSel = 3'b000; ALU_FunSel = 4'h4;
    #1;
    $display("txn add 7F+01");
    chk8("add A", AOut, 8'h7F);
    chk8("add B", BOut, 8'h01);
    chk8("add ALUOut", ALUOut, 8'h80);
    tick();
    chk8("add flags", {4'h0, ALUOutFlag}, 8'h03);

    ARF_RegSel = 4'b0100; ARF_FunSel = 2'b11; ARF_OutDSel = 2'b00;
    repeat (5) tick();
    idle(); RF_OutASel = 3'b000; RF_OutBSel = 3'b000; ALU_FunSel = 4'h4;
    #1;
    $display("txn memory write 02 at AR");
    chk8("AR Address", Address, 8'h05);
    chk8("1+1 ALUOut", ALUOut, 8'h02);
    Mem_CS = 1'b0; Mem_WR = 1'b1;
    tick();
    Mem_WR = 1'b0;
    #1;
    chk8("mem read", MemoryOut, 8'h02);
    Mem_CS = 1'b1;
    #1;
    chk8("mem deselected", MemoryOut, 8'h00);

    Mem_CS = 1'b0; IR_Enable = 1'b1; IR_Funsel = 2'b01; IR_LH = 1'b1;
    tick();
    idle();
    #1;
    $display("txn IR load high");
    chk16("IR high", IROut, 16'h0200);

    RF_TSel = 4'b0010; RF_FunSel = 2'b11;
    repeat (149) tick();
    idle(); RF_OutASel = 3'b010; ALU_FunSel = 4'h0;
    #1;
    chk8("T3 ALUOut", ALUOut, 8'h95);
    Mem_CS = 1'b0; Mem_WR = 1'b1;
    tick();
    Mem_WR = 1'b0;
    #1;
    chk8("mem read 95", MemoryOut, 8'h95);
    IR_Enable = 1'b1; IR_Funsel = 2'b01; IR_LH = 1'b0;
    tick();
    IR_Enable = 1'b0;
    #1;
    $display("txn IR load low");
    chk16("IR low", IROut, 16'h0295);
    IR_Enable = 1'b1; IR_Funsel = 2'b10;
    tick();
    IR_Enable = 1'b0;
    #1;
    chk16("IR dec", IROut, 16'h0294);
    IR_Enable = 1'b1; IR_Funsel = 2'b00;
    tick();
    IR_Funsel = 2'b10;
    tick();
    IR_Enable = 1'b0;
    #1;
    chk16("IR dec wrap", IROut, 16'hFFFF);
    IR_Enable = 1'b1; IR_Funsel = 2'b11;
    tick();
    IR_Enable = 1'b0;
    #1;
    chk16("IR inc wrap", IROut, 16'h0000);
    tick();
    chk16("IR hold", IROut, 16'h0000);
    idle();

    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 3; k++) begin
        ALU_FunSel = 4'(op); RF_OutASel = a_tab[k]; RF_OutBSel = b_tab[k];
        MuxCSel = (k == 2);
        ARF_OutCSel = 2'(k);
        $display("txn alu op=%h a_sel=%0d b_sel=%0d muxc=%0d", op, a_tab[k], b_tab[k], MuxCSel);
        tick();
      end
    end

    for (int s = 0; s < 4; s++) begin
      MuxASel = 2'(s); MuxBSel = 2'(s); ARF_OutCSel = 2'((s + 1) % 4);
      ALU_FunSel = 4'h9; Mem_CS = 1'b0;
      RF_RSel = 4'b0100 >> (s % 3); RF_FunSel = 2'b01;
      ARF_RegSel = (s == 3) ? 4'b1001 : 4'b0010; ARF_FunSel = 2'b01;
      $display("txn mux load sel=%0d", s);
      tick();
    end
    idle();
    ARF_RegSel = 4'b0001; ARF_FunSel = 2'b10;
    tick();
    idle();

    RF_TSel = 4'b1111; RF_RSel = 4'b1111; RF_FunSel = 2'b11;
    ARF_RegSel = 4'b1111; ARF_FunSel = 2'b11; IR_Enable = 1'b1; IR_Funsel = 2'b11;
    Reset = 1'b0;
    tick();
    Reset = 1'b1; idle(); RF_OutASel = 3'b000; ALU_FunSel = 4'h0; ARF_OutDSel = 2'b00;
    #1;
    $display("txn reset overrides enables");
    chk8("rst T1", AOut, 8'h00);
    chk16("rst IR", IROut, 16'h0000);
    chk8("rst flags", {4'h0, ALUOutFlag}, 8'h00);
    chk8("rst AR", Address, 8'h00);
    ARF_RegSel = 4'b0100; ARF_FunSel = 2'b11;
    repeat (5) tick();
    idle(); Mem_CS = 1'b0;
    #1;
    chk8("mem survives reset", MemoryOut, 8'h95);
    tick();
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
